// File: rtl/lsu_obi_param_pkg.sv
// lsu_obi_param_pkg: access-size and FSM-state types shared by the LSU files
// Provides ldst_size_e (funct3 encoding), lsu_state_e and size_bytes().
package lsu_obi_param_pkg;

    typedef enum logic [2:0] {
        LDST_B  = 3'd0,
        LDST_H  = 3'd1,
        LDST_W  = 3'd2,
        LDST_D  = 3'd3,
        LDST_BU = 3'd4,
        LDST_HU = 3'd5,
        LDST_WU = 3'd6
    } ldst_size_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DONE
    } lsu_state_e;

    // Low two funct3 bits give log2 of the access width in bytes.
    function automatic logic [3:0] size_bytes(input logic [2:0] size);
        return 4'(4'd1 << size[1:0]);
    endfunction

endpackage

// File: rtl/lsu_obi_param_load_align.sv
// lsu_obi_param_load_align: extracts and sign/zero-extends load data
// Ports: rdata_i raw memory word, off_i byte offset, size_i ldst_size_e,
// data_o right-aligned extended result.
module lsu_obi_param_load_align
    import lsu_obi_param_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0]           rdata_i,
    input  logic [$clog2(DW/8)-1:0] off_i,
    input  logic [2:0]              size_i,
    output logic [DW-1:0]           data_o
);

    logic [DW-1:0] sh;

    assign sh = rdata_i >> {off_i, 3'b000};

    always_comb
        data_o = size_i == LDST_B  ? DW'($signed(sh[7:0]))  :
                 size_i == LDST_BU ? DW'(sh[7:0])           :
                 size_i == LDST_H  ? DW'($signed(sh[15:0])) :
                 size_i == LDST_HU ? DW'(sh[15:0])          :
                 size_i == LDST_W  ? DW'($signed(sh[31:0])) :
                 size_i == LDST_WU ? DW'(sh[31:0])          : sh;

endmodule

// File: rtl/lsu_obi_param.sv
// lsu_obi_param: parametrised load/store unit with OBI req/gnt/rvalid handshake
// Ports: clk_i/arst_i clock and async reset; lsu_* core side (request, stall,
// load result, misalign and timeout flags); data_* OBI memory side.
module lsu_obi_param
    import lsu_obi_param_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              lsu_req_i,
    input  logic              lsu_we_i,
    input  logic [2:0]        lsu_size_i,
    input  logic [AW-1:0]     lsu_addr_i,
    input  logic [DW-1:0]     lsu_data_i,
    output logic              lsu_stall_req_o,
    output logic [DW-1:0]     lsu_data_o,
    output logic              lsu_misalign_o,
    output logic              lsu_err_o,
    output logic              data_req_o,
    input  logic              data_gnt_i,
    output logic              data_we_o,
    output logic [DW/8-1:0]   data_be_o,
    output logic [AW-1:0]     data_addr_o,
    output logic [DW-1:0]     data_wdata_o,
    input  logic              data_rvalid_i,
    input  logic [DW-1:0]     data_rdata_i
);

    localparam int NB = DW / 8;
    localparam int OW = $clog2(NB);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    lsu_state_e    state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          req_q, we_q, err_q;
    logic [NB-1:0] be_q, be_w;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q, wdata_w, ldata_q, ld_w;
    logic [2:0]    size_q;
    logic [OW-1:0] off_q;
    logic [3:0]    nbytes;
    logic          mis, tmo, to_done;

    assign nbytes = size_bytes(lsu_size_i);

    // Undefined funct3 and 64-bit-only sizes on a 32-bit bus are reported as misaligned.
    assign mis = lsu_size_i == 3'd7 ||
                 (DW == 32 && (lsu_size_i == LDST_D || lsu_size_i == LDST_WU)) ||
                 (lsu_addr_i[OW-1:0] & OW'(nbytes - 4'd1)) != '0;

    // Counter equals cycles already spent in the current wait state.
    assign tmo = TIMEOUT != 0 && cnt_q == TW'(TIMEOUT - 1);

    // A real gnt/rvalid wins over a timeout landing in the same cycle.
    assign to_done = tmo && ((state_q == S_REQ && !data_gnt_i) ||
                             (state_q == S_RESP && !data_rvalid_i));

    assign cnt_d = (state_d == state_q && (state_q == S_REQ || state_q == S_RESP)) ?
                   cnt_q + 1'b1 : '0;

    assign be_w = NB'(((16'd1 << nbytes) - 16'd1) << lsu_addr_i[OW-1:0]);

    always_comb
        wdata_w = lsu_size_i[1:0] == 2'd0 ? {NB{lsu_data_i[7:0]}}         :
                  lsu_size_i[1:0] == 2'd1 ? {(NB/2){lsu_data_i[15:0]}}    :
                  lsu_size_i[1:0] == 2'd2 ? {(NB/4){lsu_data_i[31:0]}}    : lsu_data_i;

    lsu_obi_param_load_align #(.DW(DW)) u_align (
        .rdata_i (data_rdata_i),
        .off_i   (off_q),
        .size_i  (size_q),
        .data_o  (ld_w)
    );

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = (lsu_req_i && !mis) ? S_REQ : S_IDLE;
            S_REQ:   state_d = data_gnt_i ? S_RESP : (tmo ? S_DONE : S_REQ);
            S_RESP:  state_d = (data_rvalid_i || tmo) ? S_DONE : S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        lsu_misalign_o  = state_q == S_IDLE && lsu_req_i && mis;
        lsu_stall_req_o = lsu_req_i && !mis && state_q != S_DONE;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            off_q   <= '0;
            ldata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state_q == S_IDLE && state_d == S_REQ) begin
                req_q   <= 1'b1;
                we_q    <= lsu_we_i;
                be_q    <= be_w;
                addr_q  <= {lsu_addr_i[AW-1:OW], {OW{1'b0}}};
                wdata_q <= wdata_w;
                size_q  <= lsu_size_i;
                off_q   <= lsu_addr_i[OW-1:0];
            end
            if (state_q == S_REQ && data_gnt_i)
                req_q <= 1'b0;
            if (state_q == S_RESP && data_rvalid_i && !we_q)
                ldata_q <= ld_w;
            if (to_done) begin
                req_q   <= 1'b0;
                err_q   <= 1'b1;
                ldata_q <= '0;
            end
            if (state_q == S_DONE)
                err_q <= 1'b0;
        end
    end

    assign data_req_o   = req_q;
    assign data_we_o    = we_q;
    assign data_be_o    = be_q;
    assign data_addr_o  = addr_q;
    assign data_wdata_o = wdata_q;
    assign lsu_data_o   = ldata_q;
    assign lsu_err_o    = err_q;

endmodule
